// File: rtl/debug_run_controller_pkg.sv
// Shared debug definitions: run-controller state codes and default timing
// constants, also consumed by the display unit.
package debug_run_controller_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } state_t;

  // 20 ms of stable samples at a 500 Hz sampling clock
  localparam int DEB_CYCLES_DEFAULT = 10;
  localparam int CNT_W_DEFAULT      = 16;

endpackage

// File: rtl/debug_run_controller_if.sv
// Bundle of the run controller's operator inputs, pipeline hooks and
// status outputs. The controller sits on the slave side.
interface debug_run_controller_if #(
  parameter int CNT_W = 16
) ();

  logic             i_cont;
  logic             i_step;
  logic             i_inc;
  logic             i_dec;
  logic [31:0]      i_pc;
  logic             i_bpEn;
  logic [31:0]      i_bpAddr;
  logic             o_cpuEn;
  logic [7:0]       o_dbgAddr;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_runCycles;
  logic [15:0]      o_led;

  modport slave (
    input  i_cont, i_step, i_inc, i_dec, i_pc, i_bpEn, i_bpAddr,
    output o_cpuEn, o_dbgAddr, o_state, o_runCycles, o_led
  );

  modport master (
    output i_cont, i_step, i_inc, i_dec, i_pc, i_bpEn, i_bpAddr,
    input  o_cpuEn, o_dbgAddr, o_state, o_runCycles, o_led
  );

endinterface

// File: rtl/debug_run_controller_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability debouncer and
// a single-cycle pulse on each accepted press.
module btn_debounce
  import debug_run_controller_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_pulse;

  // Bring the raw button into the clock domain before any decision is made
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_btn};
    end
  end

  // Flip the accepted level only after DEB_CYCLES consecutive differing samples; pulse on press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
          r_pulse <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/debug_run_controller.sv
// Debug run controller: free-run / single-step / breakpoint FSM driving the
// pipeline clock enable, plus the debug address and executed-cycle counters.
module debug_run_controller
  import debug_run_controller_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  debug_run_controller_if.slave  bus
);

  logic [1:0]       r_contSync;
  state_t           r_state;
  logic [7:0]       r_dbgAddr;
  logic [CNT_W-1:0] r_runCycles;

  state_t w_nextState;
  logic   w_cpuEn;
  logic   w_contS;
  logic   w_bpHit;
  logic   w_stepPulse;
  logic   w_incPulse;
  logic   w_decPulse;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_stepBtn (
    .clk(clk), .rst_n(rst_n), .i_btn(bus.i_step), .o_pulse(w_stepPulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_incBtn (
    .clk(clk), .rst_n(rst_n), .i_btn(bus.i_inc), .o_pulse(w_incPulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_decBtn (
    .clk(clk), .rst_n(rst_n), .i_btn(bus.i_dec), .o_pulse(w_decPulse)
  );

  assign w_contS = r_contSync[1];
  assign w_bpHit = bus.i_bpEn && (bus.i_pc == bus.i_bpAddr);

  // The run switch is a level, so synchronizing it is enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_contSync <= 2'b00;
    end else begin
      r_contSync <= {r_contSync[0], bus.i_cont};
    end
  end

  // State register; reset drops straight to HALT so no stray enable cycle escapes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HALT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and clock enable; a breakpoint hit withholds the enable in the hit cycle
  always_comb begin
    w_nextState = r_state;
    w_cpuEn     = 1'b0;
    case (r_state)
      HALT: begin
        if (w_contS) begin
          w_nextState = RUN;
        end else if (w_stepPulse) begin
          w_nextState = STEP;
        end
      end
      RUN: begin
        w_cpuEn = !w_bpHit;
        if (!w_contS) begin
          w_nextState = HALT;
        end else if (w_bpHit) begin
          w_nextState = BREAK;
        end
      end
      STEP: begin
        w_cpuEn     = 1'b1;
        w_nextState = HALT;
      end
      BREAK: begin
        if (w_stepPulse) begin
          w_nextState = STEP;
        end else if (!w_contS) begin
          w_nextState = HALT;
        end
      end
      default: begin
        w_nextState = HALT;
      end
    endcase
  end

  // Debug address walks with the inc/dec buttons in any state; a simultaneous press cancels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbgAddr <= 8'h00;
    end else begin
      case ({w_incPulse, w_decPulse})
        2'b10:   r_dbgAddr <= r_dbgAddr + 8'h01;
        2'b01:   r_dbgAddr <= r_dbgAddr - 8'h01;
        default: r_dbgAddr <= r_dbgAddr;
      endcase
    end
  end

  // Count executed cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_runCycles <= '0;
    end else if (w_cpuEn && (r_runCycles != {CNT_W{1'b1}})) begin
      r_runCycles <= r_runCycles + 1'b1;
    end
  end

  assign bus.o_cpuEn     = w_cpuEn;
  assign bus.o_dbgAddr   = r_dbgAddr;
  assign bus.o_state     = r_state;
  assign bus.o_runCycles = r_runCycles;
  assign bus.o_led       = {bus.i_pc[9:2], r_dbgAddr};

endmodule

// File: doc/debug_run_controller.md
DEBUG_RUN_CONTROLLER -- requirements
Module: debug_run_controller

Interface
REQ-001 Parameter DEB_CYCLES, default 10, number of consecutive stable samples a button needs to be accepted (20 ms at 500 Hz).
REQ-002 Parameter CNT_W, default 16, width of the executed-cycle counter.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cont  in  1  raw run switch level; 1 = free run.
REQ-007 step  in  1  raw single-step push button.
REQ-008 inc  in  1  raw push button; increments debug address.
REQ-009 dec  in  1  raw push button; decrements debug address.
REQ-010 pc  in  32  current fetch PC of the pipeline.
REQ-011 bp_en  in  1  breakpoint enable.
REQ-012 bp_addr  in  32  breakpoint PC.
REQ-013 cpu_en  out  1  pipeline clock enable; all pipeline registers advance only when 1.
REQ-014 dbg_addr  out  8  register-file/memory address for the display unit.
REQ-015 state_o  out  2  current state code.
REQ-016 run_cycles  out  CNT_W  count of cycles with cpu_en=1.
REQ-017 led  out  16  {pc[9:2], dbg_addr}.

Function
REQ-018 cont SHALL pass through a 2-flop synchronizer (cont_s) before use.
REQ-019 Each of step, inc and dec SHALL be 2-flop synchronized, then debounced: the debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles.
REQ-020 A debounced rising edge SHALL produce exactly one 1-cycle pulse; a held button produces no further pulses; the release edge produces none.
REQ-021 The FSM states SHALL be HALT=0, RUN=1, STEP=2, BREAK=3, each driven on state_o.
REQ-022 HALT: cont_s=1 -> RUN; else step pulse -> STEP; else stay. cont_s has priority.
REQ-023 RUN: cont_s=0 -> HALT; else bp_hit -> BREAK; else stay.
REQ-024 bp_hit SHALL equal bp_en AND (pc == bp_addr), full 32-bit compare.
REQ-025 STEP SHALL last exactly one cycle and then go to HALT unconditionally.
REQ-026 BREAK: step pulse -> STEP; else cont_s=0 -> HALT; else stay.
REQ-027 cpu_en SHALL be combinational: 1 in STEP, 1 in RUN when bp_hit=0, otherwise 0. The PC therefore freezes at bp_addr in the hit cycle.
REQ-028 Resuming from BREAK with cont_s=1 SHALL follow BREAK->STEP->HALT->RUN. The PC moves past bp_addr, so the breakpoint does not immediately re-trigger.
REQ-029 dbg_addr SHALL change as follows:
- inc pulse alone: +1, wrapping 255->0.
- dec pulse alone: -1, wrapping 0->255.
- both pulses in the same cycle: unchanged.
- updates occur in every state.
REQ-030 run_cycles SHALL increment by 1 in each cycle with cpu_en=1 and saturate at all-ones.

Reset
REQ-031 Assertion of rst (0) SHALL immediately force the following, regardless of clk:
- state=HALT, so cpu_en=0.
- dbg_addr=0.
- run_cycles=0.
- all synchronizers, debounce counters and debounced levels to 0.
REQ-032 After release, a button held through reset SHALL produce one pulse once debounced. A switch already at 1 SHALL reach RUN after 2 synchronizer cycles plus 1 FSM cycle.
REQ-033 Reset in mid-STEP or mid-BREAK SHALL abort without issuing an extra cpu_en cycle.

Structure
REQ-034 The state codes (HALT/RUN/STEP/BREAK) and the default DEB_CYCLES SHALL live in the shared debug package, used by this block and the display unit.
REQ-035 Synchronize, debounce and edge-pulse logic SHALL be one sub-module, btn_debounce (parameter DEB_CYCLES), instantiated three times.
REQ-036 The FSM, address counter and cycle counter SHALL reside in the top module; no gated clocks are generated.

Verification (DEB_CYCLES=4)
REQ-037 Reset stimulus: rst=0 with all inputs 1 -> cpu_en=0, dbg_addr=0, run_cycles=0, state_o=0. After release, state_o=1 within 3 cycles.
REQ-038 Step stimulus: cont=0, step held for 20 cycles -> exactly one cycle of state_o=2 and cpu_en=1, then run_cycles=1.
REQ-039 Bounce stimulus: step toggled every 2 cycles for 12 cycles, then released -> no pulse and cpu_en stays 0.
REQ-040 Breakpoint stimulus: cont=1, bp_en=1, bp_addr=0x0000000C, pc model +4 per cpu_en -> pc stops at 0x0C, state_o=3, cpu_en=0. A step press then gives pc=0x10 and a return to RUN.
REQ-041 Address wrap stimulus: dbg_addr=0, then a dec press -> 0xFF, then an inc press -> 0x00. Forced simultaneous inc/dec pulses -> unchanged. led[7:0] tracks dbg_addr.
REQ-042 Saturation stimulus: CNT_W=4, cont=1 for 20 cycles -> run_cycles=0xF and held there.
